// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: issues pair reads to instruction memory, buffers pairs in a FIFO,
// and presents one instruction per cycle. Optional macro FETCH_BYPASS_EN: empty-FIFO bypass of returning pair.
module inst_fetch_queue #(
  parameter int unsigned           WORD_SIZE  = 32,
  parameter int unsigned           BLOCK_SIZE = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [WORD_SIZE-1:0]  RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [WORD_SIZE-1:0]          mem_addr,
  output logic                          mem_readable,
  output logic                          mem_writable,
  output logic [BLOCK_SIZE-1:0]         mem_write,
  input  logic [BLOCK_SIZE-1:0]         mem_out1,
  input  logic [BLOCK_SIZE-1:0]         mem_out2,
  input  logic                          redirect,
  input  logic [WORD_SIZE-1:0]          redirect_pc,
  output logic                          inst_valid,
  output logic [BLOCK_SIZE-1:0]         inst,
  output logic [WORD_SIZE-1:0]          inst_pc,
  input  logic                          inst_ready,
  output logic [$clog2(DEPTH):0]        level
);

  localparam int unsigned IS = BLOCK_SIZE / 8;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned RW = LW + 2;
  localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(IS - 1);
  localparam logic [WORD_SIZE-1:0] PAIR_STEP  = WORD_SIZE'(2 * IS);

  typedef struct packed {
    logic [WORD_SIZE-1:0]  pc;
    logic [BLOCK_SIZE-1:0] ins;
  } entry_t;

  logic [WORD_SIZE-1:0] fetch_pc;
  logic [WORD_SIZE-1:0] ret_pc;
  entry_t               fifo [DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic                 inflight;
  logic                 squash;
  entry_t               head;
  logic                 head_valid;

  logic                 ret_ok;
  logic                 bypass;
  logic                 pop;
  logic                 fifo_pop;
  logic [1:0]           n_wr;
  entry_t               e1;
  entry_t               e2;
  entry_t               wdata0;
  entry_t               wdata1;
  entry_t               head_nxt;
  logic [LW-1:0]        level_nxt;
  logic [PW-1:0]        rd_nxt;
  logic [PW-1:0]        wr_nxt;
  logic [RW-1:0]        resv;
  logic                 issue;

  assign mem_writable = 1'b0;
  assign mem_write    = '0;

  // Head selection, enqueue/dequeue bookkeeping and request reservation
  always_comb begin
    ret_ok = inflight && !squash;
`ifdef FETCH_BYPASS_EN
    bypass = ret_ok && (level == '0);
`else
    bypass = 1'b0;
`endif
    e1.pc  = ret_pc;
    e1.ins = mem_out1;
    e2.pc  = ret_pc + WORD_SIZE'(IS);
    e2.ins = mem_out2;

    inst_valid = bypass ? 1'b1     : head_valid;
    inst       = bypass ? mem_out1 : head.ins;
    inst_pc    = bypass ? ret_pc   : head.pc;

    pop      = inst_valid && inst_ready;
    fifo_pop = pop && !bypass;

    if (!ret_ok)             n_wr = 2'd0;
    else if (bypass && pop)  n_wr = 2'd1;
    else                     n_wr = 2'd2;

    wdata0 = (n_wr == 2'd1) ? e2 : e1;
    wdata1 = e2;

    level_nxt = level + LW'(n_wr) - LW'(fifo_pop);
    rd_nxt    = rd_ptr + PW'(fifo_pop);
    wr_nxt    = wr_ptr + PW'(n_wr);
    // Once the old contents are drained, the new head is the first word written this edge
    head_nxt  = ((level - LW'(fifo_pop)) == '0) ? wdata0 : fifo[rd_nxt];

    resv  = RW'(level) + RW'({mem_readable, 1'b0}) + RW'({ret_ok, 1'b0}) + RW'(2);
    issue = (resv <= RW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc     <= RESET_PC;
      mem_addr     <= RESET_PC;
      mem_readable <= 1'b0;
      ret_pc       <= '0;
      inflight     <= 1'b0;
      squash       <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      level        <= '0;
      head         <= '0;
      head_valid   <= 1'b0;
    end else begin
      ret_pc   <= mem_addr;
      inflight <= mem_readable;
      if (redirect) begin
        // A request visible now returns next cycle and must be dropped
        squash       <= mem_readable;
        fetch_pc     <= redirect_pc & ALIGN_MASK;
        mem_readable <= 1'b0;
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        level        <= '0;
        head_valid   <= 1'b0;
      end else begin
        squash       <= 1'b0;
        mem_readable <= issue;
        if (issue) begin
          mem_addr <= fetch_pc;
          fetch_pc <= fetch_pc + PAIR_STEP;
        end
        rd_ptr     <= rd_nxt;
        wr_ptr     <= wr_nxt;
        level      <= level_nxt;
        head_valid <= (level_nxt != '0);
        if (level_nxt != '0) head <= head_nxt;
      end
    end
  end

  // Entry storage; contents are only meaningful between rd_ptr and wr_ptr
  always_ff @(posedge clk) begin
    if (!redirect) begin
      if (n_wr != 2'd0) fifo[wr_ptr] <= wdata0;
      if (n_wr == 2'd2) fifo[wr_ptr + PW'(1)] <= wdata1;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue with a stream-level reference model and registered memory model.
module tb_inst_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_readable;
  logic        mem_writable;
  logic [31:0] mem_write;
  logic [31:0] mem_out1 = '0;
  logic [31:0] mem_out2 = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic [2:0]  level;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_level;
  bit          ret_pend;
  bit          exp_mr;
  logic [31:0] exp_pc;
  logic [31:0] req_pc;

  inst_fetch_queue #(.WORD_SIZE(32), .BLOCK_SIZE(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_readable(mem_readable),
    .mem_writable(mem_writable), .mem_write(mem_write), .mem_out1(mem_out1), .mem_out2(mem_out2),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .level(level)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] code(input logic [31:0] pc);
    return (pc * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Synchronous instruction memory returning the pair one cycle after the strobe
  always @(posedge clk) begin
    if (mem_readable) begin
      mem_out1 <= code(mem_addr);
      mem_out2 <= code(mem_addr + 32'd4);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_init();
    m_level  = 0;
    ret_pend = 1'b0;
    exp_mr   = 1'b0;
    exp_pc   = RPC;
    req_pc   = RPC;
  endtask

  // Called at a negedge; drives one cycle of inputs, checks, advances the model, returns at next negedge
  task automatic cycle(input logic rdy, input logic rd, input logic [31:0] rpc);
    bit pop;
    int pend;
    inst_ready  = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    chk("level", 32'(level), 32'(m_level));
`ifdef FETCH_BYPASS_EN
    chk("inst_valid", 32'(inst_valid), 32'((m_level != 0) || ret_pend));
`else
    chk("inst_valid", 32'(inst_valid), 32'(m_level != 0));
`endif
    if (inst_valid) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst", inst, code(exp_pc));
    end
    chk("mem_readable", 32'(mem_readable), 32'(exp_mr));
    if (mem_readable) begin
      chk("mem_addr", mem_addr, req_pc);
      req_pc = req_pc + 32'd8;
    end
    pop = inst_valid && rdy;
    if (pop) exp_pc = exp_pc + 32'd4;
    if (rd) begin
      m_level  = 0;
      ret_pend = 1'b0;
      exp_mr   = 1'b0;
      exp_pc   = rpc & ~32'h3;
      req_pc   = rpc & ~32'h3;
    end else begin
      pend     = int'(mem_readable) + int'(ret_pend);
      exp_mr   = (DEPTH - m_level - 2 * pend) >= 2;
      m_level  = m_level + (ret_pend ? 2 : 0) - int'(pop);
      ret_pend = mem_readable;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, RPC);
    chk({tag, "_mem_readable"}, 32'(mem_readable), 32'd0);
    chk({tag, "_mem_writable"}, 32'(mem_writable), 32'd0);
    chk({tag, "_mem_write"}, mem_write, 32'd0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst"}, inst, 32'd0);
    chk({tag, "_inst_pc"}, inst_pc, 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
  endtask

  // Asserts reset between edges, checks outputs immediately, releases at a negedge
  task automatic do_reset(input string tag);
    #2;
    rst_n      = 1'b0;
    redirect   = 1'b0;
    inst_ready = 1'b0;
    #1;
    check_reset_values(tag);
    repeat (2) @(negedge clk);
    check_reset_values({tag, "_hold"});
    rst_n = 1'b1;
    model_init();
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < 5) cycle(1'($urandom_range(1)), 1'b1, $urandom);
      else cycle(1'($urandom_range(99) < 70), 1'b0, 32'd0);
    end
  endtask

  initial begin
    bit found;
    model_init();
    @(negedge clk);
    do_reset("reset");

    // Free-running stream from RESET_PC
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 32'd0);

    // Decoder stall: FIFO fills, requests stop, then drains in order
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'd0);
    chk("stall_level", 32'(level), 32'(DEPTH));
    chk("stall_no_req", 32'(mem_readable), 32'd0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 32'd0);

    // Redirect with a request in flight
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_readable) found = 1'b1;
      else cycle(1'b1, 1'b0, 32'd0);
    end
    chk("inflight_found", 32'(found), 32'd1);
    cycle(1'b1, 1'b1, 32'h203);
    chk("redir_level", 32'(level), 32'd0);
    chk("redir_no_req", 32'(mem_readable), 32'd0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 32'd0);

    // Address wrap through zero
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 20; i++) cycle(1'($urandom_range(1)), 1'b0, 32'd0);

    run_random(300);

    // Asynchronous reset in the middle of traffic
    do_reset("midreset");
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'd0);
    run_random(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
